// File: rtl/myproject_mul_arb_pkg.sv
// -----------------------------------------------------------------------------
// myproject_mul_arb_pkg
// Shared widths and helpers for the shared-multiplier round-robin arbiter.
//   A_W    : default operand A width (unsigned)
//   B_W    : default operand B width (signed two's complement)
//   P_W    : default registered product width (signed)
//   STAT_W : width of the per-requester grant counters
//   prod_w : full-precision product width for an unsigned x signed multiply
// -----------------------------------------------------------------------------
package myproject_mul_arb_pkg;

  localparam int A_W    = 6;
  localparam int B_W    = 6;
  localparam int P_W    = 12;
  localparam int STAT_W = 16;

  // Operand A gains a zero sign bit so it can enter a signed multiply, hence +1.
  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

endpackage

// File: rtl/myproject_mul_rr_pick.sv
// -----------------------------------------------------------------------------
// myproject_mul_rr_pick
// Purely combinational round-robin picker. Selects the first asserted request
// starting at ptr_i and searching upward, wrapping modulo N.
//   req_i   [N]      request vector
//   ptr_i   [IDX_W]  round-robin start index (values >= N are treated as 0)
//   grant_o [N]      one-hot grant
//   idx_o   [IDX_W]  binary index of the granted request (0 when none)
//   any_o            at least one request is asserted
// -----------------------------------------------------------------------------
module myproject_mul_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int ptr_eff;
  int idx;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    ptr_eff = (int'(ptr_i) < N) ? int'(ptr_i) : 0;
    idx     = 0;
    // Walk offsets from farthest to nearest so the nearest hit wins last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr_eff + k;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) begin
        idx_o = IDX_W'(idx);
        any_o = 1'b1;
      end
    end
    if (any_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/myproject_mul_arbiter.sv
// -----------------------------------------------------------------------------
// myproject_mul_arbiter
// Round-robin arbiter sharing one unsigned x signed multiplier between NUM_REQ
// requesters. The winning operand pair is multiplied and registered with its
// requester tag onto a single valid/ready output stream (1-cycle latency,
// full throughput).
//
// Ports:
//   ap_clk, ap_rst_n          clock (rising edge), async active-low reset
//   req_valid/req_ready [N]   per-requester handshake
//   req_a [N*A_W], req_b [N*B_W]  packed operands, requester i at [i*W +: W]
//   out_valid/out_ready       product stream handshake
//   out_p [P_W], out_id [ID_W]    signed product and requester tag
//   stat_sel [ID_W], stat_cnt [16] grant counter read port
//
// Optional feature: define MYPROJECT_MUL_ARB_STATS_EN to build one 16-bit
// saturating grant counter per requester. Otherwise stat_cnt is tied to 0.
// -----------------------------------------------------------------------------
module myproject_mul_arbiter
  import myproject_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_W     = myproject_mul_arb_pkg::A_W,
  parameter int B_W     = myproject_mul_arb_pkg::B_W,
  parameter int P_W     = myproject_mul_arb_pkg::P_W,
  parameter int ID_W    = 2
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*A_W-1:0]   req_a,
  input  logic [NUM_REQ*B_W-1:0]   req_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [P_W-1:0]    out_p,
  output logic [ID_W-1:0]          out_id,
  input  logic [ID_W-1:0]          stat_sel,
  output logic [STAT_W-1:0]        stat_cnt
);

  localparam int PROD_W = prod_w(A_W, B_W);

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [P_W-1:0] out_p_q, out_p_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;

  logic [NUM_REQ-1:0]    grant_oh;
  logic [ID_W-1:0]       grant_idx;
  logic                  any_req;
  logic                  slot_free;
  logic                  accept;

  logic [A_W-1:0]           a_sel;
  logic signed [B_W-1:0]    b_sel;
  logic signed [PROD_W-1:0] prod;

  myproject_mul_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_oh),
    .idx_o   (grant_idx),
    .any_o   (any_req)
  );

  // The output register can take a new product when empty or draining now.
  assign slot_free = !out_valid_q || out_ready;
  // Reset gating keeps ready low during reset even though the slot looks free.
  assign req_ready = (slot_free && ap_rst_n) ? grant_oh : '0;
  assign accept    = any_req && slot_free;

  assign a_sel = req_a[int'(grant_idx)*A_W +: A_W];
  assign b_sel = req_b[int'(grant_idx)*B_W +: B_W];
  // A is zero-extended to become a non-negative signed operand.
  assign prod  = PROD_W'($signed({1'b0, a_sel})) * PROD_W'(b_sel);

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    out_id_d    = out_id_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_p_d     = P_W'(prod);
      out_id_d    = grant_idx;
      rr_ptr_d    = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end else if (out_ready) begin
      // Drain with nothing to replace it; data fields keep their last values.
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign out_id    = out_id_q;

`ifdef MYPROJECT_MUL_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];

  // NOTE: the counter array is small and architecturally visible, so every
  // entry is reset explicitly rather than left to power-up contents.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && grant_oh[i] && (stat_q[i] != '1)) stat_q[i] <= stat_q[i] + 1'b1;
      end
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(stat_sel) == i) stat_cnt = stat_q[i];
    end
  end
`else
  assign stat_cnt = '0;
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
`endif

endmodule

// File: tb/tb_myproject_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_myproject_mul_arbiter
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a transaction-level model of the arbiter. Works with or without
// MYPROJECT_MUL_ARB_STATS_EN defined.
// -----------------------------------------------------------------------------
module tb_myproject_mul_arbiter;

  localparam int N    = 4;
  localparam int A_W  = 6;
  localparam int B_W  = 6;
  localparam int P_W  = 12;
  localparam int ID_W = 2;
  localparam int AT_W = N * A_W;
  localparam int BT_W = N * B_W;

  logic              ap_clk;
  logic              ap_rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [AT_W-1:0]   req_a;
  logic [BT_W-1:0]   req_b;
  logic              out_valid;
  logic              out_ready;
  logic [P_W-1:0]    out_p;
  logic [ID_W-1:0]   out_id;
  logic [ID_W-1:0]   stat_sel;
  logic [15:0]       stat_cnt;

  myproject_mul_arbiter #(
    .NUM_REQ (N),
    .A_W     (A_W),
    .B_W     (B_W),
    .P_W     (P_W),
    .ID_W    (ID_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_id    (out_id),
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Transaction-level model state.
  int m_valid;
  int m_p;
  int m_id;
  int m_ptr;
  int m_cnt [N];

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_p     = 0;
    m_id    = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // First valid requester at or after ptr, wrapping; -1 when none.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*A_W +: A_W] = A_W'(a);
    req_b[i*B_W +: B_W] = B_W'(b);
  endtask

  // Called just after a falling edge with inputs already driven: compare all
  // outputs against the model, then advance the model across the rising edge.
  task automatic cycle();
    int g;
    int slot;
    int a;
    int b;
    logic [N-1:0] exp_rdy;
    int exp_stat;
    #1;
    g       = pick(req_valid, m_ptr);
    slot    = (m_valid == 0 || out_ready) ? 1 : 0;
    exp_rdy = (slot != 0 && g >= 0) ? N'(1 << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_p", 32'(out_p), 32'(m_p));
    check("out_id", 32'(out_id), 32'(m_id));
`ifdef MYPROJECT_MUL_ARB_STATS_EN
    exp_stat = (int'(stat_sel) < N) ? m_cnt[stat_sel] : 0;
`else
    exp_stat = 0;
`endif
    check("stat_cnt", 32'(stat_cnt), 32'(exp_stat));
    @(posedge ap_clk);
    if (slot != 0 && g >= 0) begin
      a       = int'(req_a[g*A_W +: A_W]);
      b       = int'($signed(req_b[g*B_W +: B_W]));
      m_p     = (a * b) & 32'hFFF;
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % N;
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(negedge ap_clk);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    ap_rst_n  = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b1;
    stat_sel  = '0;
    model_reset();

    // Reset state: ready stays low even with every requester valid.
    repeat (2) @(negedge ap_clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_p", 32'(out_p), 32'h0);
    check("rst_id", 32'(out_id), 32'h0);
    check("rst_stat", 32'(stat_cnt), 32'h0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Single request at the negative extreme, then the positive extreme.
    req_valid = 4'b0001;
    set_req(0, 63, -32);
    cycle();
    check("single_neg_p", 32'(out_p), 32'h820);
    check("single_neg_id", 32'(out_id), 32'h0);
    set_req(0, 63, 31);
    cycle();
    check("single_pos_p", 32'(out_p), 32'h7A1);

    // rr_ptr is now 1: requesters 0 and 3 alternate starting with 3.
    req_valid = 4'b1001;
    set_req(3, 5, -7);
    cycle();
    check("fair_1", 32'(out_id), 32'd3);
    cycle();
    check("fair_2", 32'(out_id), 32'd0);
    cycle();
    check("fair_3", 32'(out_id), 32'd3);

    // All four valid with fresh operands each cycle.
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      req_a = AT_W'($urandom);
      req_b = BT_W'($urandom);
      cycle();
    end

    // Backpressure: held output, no ready; then release.
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_a = AT_W'($urandom);
      req_b = BT_W'($urandom);
      cycle();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) cycle();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      req_a     = AT_W'($urandom);
      req_b     = BT_W'($urandom);
      out_ready = ($urandom_range(9, 0) < 7);
      stat_sel  = ID_W'($urandom);
      cycle();
    end

    // Async reset between edges while a product is held.
    req_valid = '1;
    out_ready = 1'b1;
    cycle();
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    model_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    cycle();
    check("restart_id", 32'(out_id), 32'h0);
    cycle();

`ifdef MYPROJECT_MUL_ARB_STATS_EN
    // Saturate requester 2's counter.
    req_valid = 4'b0100;
    set_req(2, 9, -3);
    out_ready = 1'b1;
    stat_sel  = 2'd2;
    repeat (70000) @(posedge ap_clk);
    @(negedge ap_clk);
    m_valid  = 1;
    m_id     = 2;
    m_p      = (9 * -3) & 32'hFFF;
    m_ptr    = 3;
    m_cnt[2] = 65535;
    cycle();
    check("stat_sat", 32'(stat_cnt), 32'hFFFF);
`else
    for (int s = 0; s < N; s++) begin
      stat_sel = ID_W'(s);
      cycle();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
